hm_display_sched: RTL and testbench

HM_DISPLAY_SCHED -- requirements
Module: hm_display_sched

---
 rtl/hm_disp_pkg.sv | 19 +
 rtl/hm_page_select.sv | 26 ++
 rtl/hm_display_sched.sv | 165 ++++++++++++++++
 tb/tb_hm_display_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hm_disp_pkg.sv
// rtl/hm_disp_pkg.sv - shared types and constants for the display page scheduler (HM_SCHED_ALERT_EN adds ALERT)
package hm_disp_pkg;

    localparam int NPAGE = 4;

    typedef logic [1:0] page_t;

    typedef enum logic [1:0] {
        ST_AUTO,
        ST_MANUAL
`ifdef HM_SCHED_ALERT_EN
        ,ST_ALERT
`endif
    } state_t;

    // Tag shown on d7..d4 for each page: heart rate, steps, distance, time
    localparam logic [15:0] PAGE_TAG [NPAGE] = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};

endpackage

// File: rtl/hm_page_select.sv
// rtl/hm_page_select.sv - cyclic search for the next page with valid source data
import hm_disp_pkg::*;

module hm_page_select (
    input  page_t      cur_i,
    input  logic [3:0] vld_i,
    output page_t      nxt_o,
    output logic       found_o
);

    // Scan offsets 3..1 so the nearest valid successor is the last one written
    always_comb begin
        page_t cand;
        nxt_o   = cur_i;
        found_o = 1'b0;
        cand    = cur_i;
        for (int k = 3; k >= 1; k--) begin
            cand = cur_i + page_t'(k);
            if (vld_i[cand]) begin
                nxt_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hm_display_sched.sv
// rtl/hm_display_sched.sv - AUTO/MANUAL page scheduler for the health-monitor display (HM_SCHED_ALERT_EN adds ALERT flash)
import hm_disp_pkg::*;

module hm_display_sched #(
    parameter int DWELL   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        mode_btn,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    input  logic [3:0]  src_vld,
    input  logic        alert,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5,
    output logic [3:0]  d6,
    output logic [3:0]  d7,
    output logic        mode,
    output logic        rs_en,
    output logic [1:0]  page
);

    localparam logic [3:0] DW = DWELL[3:0];
    localparam logic [3:0] TO = TIMEOUT[3:0];

    state_t      state_q, state_d;
    page_t       page_q, page_d;
    logic [3:0]  dwell_q, dwell_d;
    logic [3:0]  idle_q, idle_d;
    logic        rs_en_q, rs_en_d;
    logic        chg_q;
    logic [15:0] data_q;
    logic [15:0] tag_q;
    logic [15:0] src_sel;
    logic [3:0]  dwell_inc, idle_inc;
    page_t       nxt_page;
    logic        nxt_found;

`ifndef HM_SCHED_ALERT_EN
    logic unused_alert;
    assign unused_alert = alert;
`endif

    hm_page_select u_sel (
        .cur_i   (page_q),
        .vld_i   (src_vld),
        .nxt_o   (nxt_page),
        .found_o (nxt_found)
    );

    // Source mux for the currently displayed page
    always_comb begin
        case (page_q)
            2'd0:    src_sel = src0;
            2'd1:    src_sel = src1;
            2'd2:    src_sel = src2;
            default: src_sel = src3;
        endcase
    end

    // Next-state logic: page rotation, manual stepping, idle timeout, alert override
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        dwell_d   = dwell_q;
        idle_d    = idle_q;
        rs_en_d   = src_vld[page_q];
        dwell_inc = (dwell_q == 4'hF) ? 4'hF : dwell_q + 4'd1;
        idle_inc  = (idle_q == 4'hF) ? 4'hF : idle_q + 4'd1;
        case (state_q)
            ST_AUTO: begin
                if (mode_btn) begin
                    state_d = ST_MANUAL;
                    idle_d  = 4'd0;
                end else if (tick) begin
                    // An invalid current page is abandoned at once rather than waiting out the dwell
                    if (!src_vld[page_q] || dwell_inc >= DW) begin
                        dwell_d = 4'd0;
                        if (nxt_found) page_d = nxt_page;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end
            end
            ST_MANUAL: begin
                if (mode_btn) begin
                    idle_d = 4'd0;
                    if (nxt_found) page_d = nxt_page;
                end else if (tick) begin
                    if (!src_vld[page_q] && nxt_found) page_d = nxt_page;
                    if (idle_inc >= TO) begin
                        state_d = ST_AUTO;
                        dwell_d = 4'd0;
                        idle_d  = 4'd0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
`ifdef HM_SCHED_ALERT_EN
            ST_ALERT: begin
                page_d  = 2'd0;
                rs_en_d = tick ? ~rs_en_q : rs_en_q;
                if (!alert) begin
                    state_d = ST_AUTO;
                    dwell_d = 4'd0;
                end
            end
`endif
            default: state_d = ST_AUTO;
        endcase
`ifdef HM_SCHED_ALERT_EN
        if (alert && state_q != ST_ALERT) begin
            state_d = ST_ALERT;
            page_d  = 2'd0;
            dwell_d = 4'd0;
            idle_d  = 4'd0;
        end
`endif
    end

    // State, counters and display registers; data refreshes after a page change or on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_AUTO;
            page_q  <= 2'd0;
            dwell_q <= 4'd0;
            idle_q  <= 4'd0;
            rs_en_q <= 1'b0;
            chg_q   <= 1'b0;
            data_q  <= 16'd0;
            tag_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            dwell_q <= dwell_d;
            idle_q  <= idle_d;
            rs_en_q <= rs_en_d;
            chg_q   <= (page_d != page_q);
            tag_q   <= PAGE_TAG[page_d];
            if (chg_q || tick) data_q <= src_sel;
        end
    end

    assign d0    = data_q[3:0];
    assign d1    = data_q[7:4];
    assign d2    = data_q[11:8];
    assign d3    = data_q[15:12];
    assign d4    = tag_q[3:0];
    assign d5    = tag_q[7:4];
    assign d6    = tag_q[11:8];
    assign d7    = tag_q[15:12];
    assign mode  = (state_q == ST_MANUAL);
    assign rs_en = rs_en_q;
    assign page  = page_q;

endmodule

// File: tb/tb_hm_display_sched.sv
// tb/tb_hm_display_sched.sv - scoreboard bench for hm_display_sched (HM_SCHED_ALERT_EN adds alert scenario)
import hm_disp_pkg::*;

module tb_hm_display_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        mode_btn = 1'b0;
    logic [15:0] src0 = 16'h0072;
    logic [15:0] src1 = 16'h1234;
    logic [15:0] src2 = 16'h0350;
    logic [15:0] src3 = 16'h1259;
    logic [3:0]  src_vld = 4'b1111;
    logic        alert = 1'b0;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic        mode, rs_en;
    logic [1:0]  page;

    int check_cnt = 0;
    int err_cnt = 0;

    localparam int K_PAGE = 0;
    localparam int K_MODE = 1;
    localparam int K_RS   = 2;
    localparam int K_DATA = 3;
    localparam int K_TAG  = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];

    hm_display_sched #(.DWELL(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .src_vld(src_vld), .alert(alert),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .mode(mode), .rs_en(rs_en), .page(page)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_val(input int kind, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic expect_pm(input logic [1:0] p, input logic m);
        expect_val(K_PAGE, {14'd0, p});
        expect_val(K_MODE, {15'd0, m});
    endtask

    function automatic logic [15:0] src_of(input logic [1:0] p);
        case (p)
            2'd0:    return src0;
            2'd1:    return src1;
            2'd2:    return src2;
            default: return src3;
        endcase
    endfunction

    // Drive one cycle, then pop and compare everything queued for it
    task automatic step(input logic t, input logic b, input string name);
        exp_t e;
        tick     = t;
        mode_btn = b;
        @(posedge clk);
        #1;
        tick     = 1'b0;
        mode_btn = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_PAGE:  chk({name, ".page"}, {14'd0, page}, e.val);
                K_MODE:  chk({name, ".mode"}, {15'd0, mode}, e.val);
                K_RS:    chk({name, ".rs_en"}, {15'd0, rs_en}, e.val);
                K_DATA:  chk({name, ".d3_d0"}, {d3, d2, d1, d0}, e.val);
                default: chk({name, ".d7_d4"}, {d7, d6, d5, d4}, e.val);
            endcase
        end
    endtask

    initial begin
        logic [1:0] p;

        step(1'b0, 1'b0, "rst0");
        expect_pm(2'd0, 1'b0);
        expect_val(K_RS, 16'd0);
        expect_val(K_DATA, 16'd0);
        expect_val(K_TAG, 16'd0);
        step(1'b1, 1'b1, "rst1");
        rst = 1'b0;
        expect_val(K_RS, 16'd1);
        expect_val(K_TAG, PAGE_TAG[0]);
        step(1'b0, 1'b0, "idle0");

        // Full rotation, two ticks per page
        for (int k = 0; k < 8; k++) begin
            p = 2'(((k + 1) / 2) % 4);
            expect_pm(p, 1'b0);
            expect_val(K_TAG, PAGE_TAG[p]);
            step(1'b1, 1'b0, "rot_tick");
            expect_val(K_DATA, src_of(p));
            step(1'b0, 1'b0, "rot_data");
        end

        // Skip an invalid page in both directions
        src_vld = 4'b0101;
        expect_val(K_RS, 16'd1);
        step(1'b0, 1'b0, "skip_idle");
        expect_pm(2'd0, 1'b0); step(1'b1, 1'b0, "skip_t1");
        expect_pm(2'd2, 1'b0); step(1'b1, 1'b0, "skip_t2");
        expect_pm(2'd2, 1'b0); step(1'b1, 1'b0, "skip_t3");
        expect_pm(2'd0, 1'b0); step(1'b1, 1'b0, "skip_t4");

        // Button beats tick at dwell=1: enter MANUAL without advancing
        src_vld = 4'b1111;
        expect_pm(2'd0, 1'b0); step(1'b1, 1'b0, "prio_t1");
        expect_pm(2'd0, 1'b1); step(1'b1, 1'b1, "prio_btn");

        // Manual stepping, idle clear on press, timeout back to AUTO
        expect_pm(2'd1, 1'b1); step(1'b0, 1'b1, "man_btn1");
        for (int k = 0; k < 5; k++) begin
            expect_pm(2'd1, 1'b1); step(1'b1, 1'b0, "man_idle5");
        end
        expect_pm(2'd2, 1'b1); step(1'b0, 1'b1, "man_btn2");
        for (int k = 0; k < 7; k++) begin
            expect_pm(2'd2, 1'b1); step(1'b1, 1'b0, "man_idle7");
        end
        expect_pm(2'd2, 1'b0); step(1'b1, 1'b0, "man_timeout");
        expect_pm(2'd2, 1'b0); step(1'b1, 1'b0, "auto_dwell_clr");
        expect_pm(2'd3, 1'b0); step(1'b1, 1'b0, "auto_adv");

        // No valid source: blank and hold, then recover to the one valid page
        src_vld = 4'b0000;
        expect_val(K_RS, 16'd0); step(1'b0, 1'b0, "none_idle");
        expect_pm(2'd3, 1'b0); step(1'b1, 1'b0, "none_t1");
        expect_pm(2'd3, 1'b0); expect_val(K_RS, 16'd0); step(1'b1, 1'b0, "none_t2");
        src_vld = 4'b0010;
        expect_val(K_RS, 16'd0); step(1'b0, 1'b0, "one_idle");
        expect_pm(2'd1, 1'b0); step(1'b1, 1'b0, "one_tick");
        expect_val(K_DATA, 16'h1234); expect_val(K_RS, 16'd1); step(1'b0, 1'b0, "one_data");

        // Reset mid-operation overrides tick and button
        rst = 1'b1;
        expect_pm(2'd0, 1'b0);
        expect_val(K_RS, 16'd0);
        expect_val(K_DATA, 16'd0);
        expect_val(K_TAG, 16'd0);
        step(1'b1, 1'b1, "mid_rst");
        rst = 1'b0;
        src_vld = 4'b1111;
        step(1'b0, 1'b0, "post_rst");

`ifdef HM_SCHED_ALERT_EN
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, "to_page2");
        expect_pm(2'd2, 1'b0); step(1'b0, 1'b0, "on_page2");
        alert = 1'b1;
        expect_pm(2'd0, 1'b0); expect_val(K_RS, 16'd1); step(1'b0, 1'b0, "alert_in");
        expect_val(K_RS, 16'd0); step(1'b1, 1'b0, "alert_flash1");
        expect_val(K_RS, 16'd1); step(1'b1, 1'b0, "alert_flash2");
        expect_pm(2'd0, 1'b0); step(1'b0, 1'b1, "alert_btn");
        alert = 1'b0;
        expect_pm(2'd0, 1'b0); step(1'b0, 1'b0, "alert_out");
        expect_pm(2'd0, 1'b0); step(1'b1, 1'b0, "alert_auto1");
        expect_pm(2'd1, 1'b0); step(1'b1, 1'b0, "alert_auto2");
`else
        alert = 1'b1;
        expect_pm(2'd0, 1'b0); step(1'b1, 1'b0, "noalert_t1");
        expect_pm(2'd1, 1'b0); step(1'b1, 1'b0, "noalert_t2");
        alert = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
